sdr_wb_arbiter: RTL

- Two-master Wishbone arbiter in front of the single Wishbone slave port of the SDRAM controller (26-bit address, dw data, byte selects, cti).
- Lets a second requester, such as a DMA engine next to the CPU, share the SDRAM controller.
- Round-robin grant, held for the whole bus cycle (cyc high), so bursts are never interleaved.
- Sits between the masters and the controller's wb_* slave pins.

---
 rtl/sdr_wb_arbiter.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/sdr_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sdr_wb_arbiter
//  Function : Two-master round-robin Wishbone arbiter in front of the SDRAM
//             controller slave port. A grant is held for the whole bus cycle
//             (cyc high), so bursts from one master are never interleaved.
//  Options  : SDR_WB_ARB_TIMEOUT_EN - stall watchdog that aborts a cycle with
//             a one-cycle error pulse to the owner after TIMEOUT stall cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module sdr_wb_arbiter #(
    parameter int dw = 32
`ifdef SDR_WB_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic              sys_clk,
    input  logic              RESET,
    // master 0
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [25:0]       m0_addr_i,
    input  logic [dw-1:0]     m0_dat_i,
    input  logic [dw/8-1:0]   m0_sel_i,
    input  logic [2:0]        m0_cti_i,
    output logic [dw-1:0]     m0_dat_o,
    output logic              m0_ack_o,
    // master 1
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [25:0]       m1_addr_i,
    input  logic [dw-1:0]     m1_dat_i,
    input  logic [dw/8-1:0]   m1_sel_i,
    input  logic [2:0]        m1_cti_i,
    output logic [dw-1:0]     m1_dat_o,
    output logic              m1_ack_o,
    // slave (SDRAM controller)
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [25:0]       s_addr_o,
    output logic [dw-1:0]     s_dat_o,
    output logic [dw/8-1:0]   s_sel_o,
    output logic [2:0]        s_cti_o,
    input  logic [dw-1:0]     s_dat_i,
    input  logic              s_ack_i
`ifdef SDR_WB_ARB_TIMEOUT_EN
    ,
    output logic              m0_err_o,
    output logic              m1_err_o
`endif
);

`ifdef SDR_WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT0  = 2'd1,
        ST_GNT1  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err0_q, err0_d;
    logic             err1_q, err1_d;
    logic             stall;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT0  = 2'd1,
        ST_GNT1  = 2'd2
    } state_t;
`endif

    state_t state_q, state_d;
    // last: master that most recently owned the bus; the other one wins a tie
    logic   last_q, last_d;

    // Read data is broadcast; it only means something alongside the owner's ack
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

`ifdef SDR_WB_ARB_TIMEOUT_EN
    assign m0_err_o = err0_q;
    assign m1_err_o = err1_q;
`endif

    // Route the owning master's request to the slave and the slave's ack back
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_cti_o  = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        case (state_q)
            ST_GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_addr_o = m0_addr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_cti_o  = m0_cti_i;
                m0_ack_o = s_ack_i;
            end
            ST_GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_addr_o = m1_addr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_cti_o  = m1_cti_i;
                m1_ack_o = s_ack_i;
            end
            default: ;
        endcase
    end

    // Arbitration decision, release on cyc drop and optional stall watchdog
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
`ifdef SDR_WB_ARB_TIMEOUT_EN
        cnt_d   = '0;
        err0_d  = 1'b0;
        err1_d  = 1'b0;
        stall   = s_stb_o & ~s_ack_i;
`endif
        case (state_q)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i)
                    state_d = last_q ? ST_GNT0 : ST_GNT1;
                else if (m0_cyc_i)
                    state_d = ST_GNT0;
                else if (m1_cyc_i)
                    state_d = ST_GNT1;
            end
            ST_GNT0: begin
                if (!m0_cyc_i) begin
                    state_d = ST_IDLE;
                    last_d  = 1'b0;
                end
`ifdef SDR_WB_ARB_TIMEOUT_EN
                else if (stall && (cnt_q == CNT_LAST)) begin
                    // last is recorded now so FLUSH knows whose cyc to wait on
                    state_d = ST_FLUSH;
                    last_d  = 1'b0;
                    err0_d  = 1'b1;
                end else if (stall) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_GNT1: begin
                if (!m1_cyc_i) begin
                    state_d = ST_IDLE;
                    last_d  = 1'b1;
                end
`ifdef SDR_WB_ARB_TIMEOUT_EN
                else if (stall && (cnt_q == CNT_LAST)) begin
                    state_d = ST_FLUSH;
                    last_d  = 1'b1;
                    err1_d  = 1'b1;
                end else if (stall) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
`ifdef SDR_WB_ARB_TIMEOUT_EN
            ST_FLUSH: begin
                if (last_q ? !m1_cyc_i : !m0_cyc_i)
                    state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; async reset gives master 0 the first tie
    always_ff @(posedge sys_clk or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
`ifdef SDR_WB_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
`ifdef SDR_WB_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
`endif
        end
    end

endmodule
`default_nettype wire
